cpu_core_param: RTL and testbench
=================================

Name: cpu_core_param

Overview:
- Parametrised successor of the team's 8-bit single-cycle CPU.
- Multi-cycle FSM core with configurable data width, PC width and register count.
- External instruction and data memories attach through req/ack handshakes, so wait-states are supported; a HALT instruction is added.
- Sits under the board top level and replaces the direct pc/imem/decoder/alu/register/memory wiring.

Parameters:
DATA_W, 8, datapath/register width (>=8)
PC_W, 6, program counter width (<=8)
NREG, 16, implemented registers (2..16); reads of index >=NREG return 0, writes ignored

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (=pc)
imem_ack  in  1  fetch data valid this cycle
imem_data  in  16  instruction word
dmem_req  out  1  data access request
dmem_we  out  1  1=store, 0=load
dmem_addr  out  DATA_W  data address
dmem_wdata  out  DATA_W  store data
dmem_rdata  in  DATA_W  load data, valid with dmem_ack
dmem_ack  in  1  data access complete this cycle
pc  out  PC_W  current program counter
zf  out  1  zero flag
halted  out  1  core is in HALT

Behaviour:
- Instruction fields:
  - op[15:12] opcode, op[11:8] dst, op[7:4] src0, op[3:0] src1.
  - imm = op[7:0], zero-extended to DATA_W or truncated/zero-extended to PC_W.
- Opcodes:
  - 0 NOP.
  - 1 LDI: dst<=imm.
  - 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR: dst<=src0 op src1.
  - 7 SHL: dst<=src0<<1. 8 SHR: dst<=src0>>1 (logical).
  - 9 LD: dst<=mem[src1]. A ST: mem[src1]<=src0.
  - B JMP: pc<=imm. C JZ: if zf. D JNZ: if !zf.
  - E reserved (=NOP). F HALT.
- Arithmetic: results truncated to DATA_W; carry/borrow discarded. zf<=(result==0) on opcodes 2-8 only; all other opcodes leave zf unchanged.
- FSM states: IDLE, FETCH, EXEC, MEM, HALT.
  - IDLE -> FETCH unconditionally on the first clock after reset release.
  - FETCH: imem_req=1, imem_addr=pc. On a clock with imem_ack=1, IR<=imem_data and go to EXEC. Otherwise stay; req stays high, addr stays stable.
  - EXEC, one cycle:
    - ALU/LDI: write dst; pc<=pc+1; go to FETCH.
    - Taken jump: pc<=imm[PC_W-1:0]. Untaken jump: pc<=pc+1. Either way go to FETCH.
    - LD/ST: go to MEM; pc unchanged.
    - HALT: go to HALT; pc unchanged.
  - MEM: dmem_req=1, dmem_addr=reg[src1], dmem_we=(opcode==A), dmem_wdata=reg[src0]. All stay stable until dmem_ack. On ack: LD writes dst<=dmem_rdata; pc<=pc+1; go to FETCH.
  - HALT: terminal; halted=1; no requests. Left only by reset.
- Request outputs are decoded from registered state only, never combinationally from ack.
- Latency:
  - ALU/jump instruction with zero-wait memory: 2 clocks (FETCH+EXEC).
  - LD/ST with zero-wait memory: 3 clocks.
  - Each wait cycle adds 1.
- PC wraps modulo 2^PC_W (pc+1 at all-ones -> 0).
- Register read-after-write: a write in EXEC/MEM is visible to the next instruction; no forwarding is needed.
- dst==src register in ALU ops reads the old value.
- Reset (async, rst=0), applied at any time including mid-handshake:
  - state=IDLE, pc=0, zf=0, all registers=0, IR=0.
  - imem_req=0, dmem_req=0, dmem_we=0, halted=0.
  - Any in-flight request is abandoned; an ack arriving while in reset is ignored.
- Ack received in a state that did not request (e.g. stray dmem_ack in FETCH) is ignored.
- dmem_addr/dmem_wdata are 0 outside MEM.

Test Plan:
- Reset/boot: rst low 3 clocks, release; zero-wait imem -> imem_req=0 during reset and in the IDLE cycle, FETCH at addr 0 on the next clock; all outputs at reset values.
- ALU + flag: LDI r1,5; LDI r2,5; SUB r3,r1,r2; JZ 0x10 -> r3=0, zf=1, pc=0x10 after 8 clocks; with DATA_W=8, ADD of 0xFF+0x01 gives 0x00, zf=1.
- Wait-states: imem_ack delayed 3 clocks, dmem_ack 2 clocks on ST r4->[r5=0x20] then LD r6<-[0x20] -> requests and addresses held stable throughout, r6 equals r4, one dmem_we=1 access then one dmem_we=0 access.
- PC wrap: PC_W=6, NOPs from pc=0x3F -> next fetch address 0x00; JMP 0xC5 -> pc=0x05.
- HALT and mid-operation reset: HALT -> halted=1, no further imem_req for 20 clocks; separately assert rst during a MEM wait -> dmem_req drops immediately (asynchronously), core refetches from 0.
- Parameters: NREG=4, DATA_W=16 -> write r7 ignored, read r7=0; LDI 0xFF zero-extends to 0x00FF; SHL of 0x8000 gives 0, zf=1.

Source files
------------

// File: rtl/cpu_core_param.sv
// Multi-cycle core (IDLE/FETCH/EXEC/MEM/HALT): ALU/jump 2 clocks, LD/ST 3 clocks, plus 1 per wait cycle.
// Backpressure: imem/dmem requests are held with stable address/data until the matching ack.
module cpu_core_param #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 6,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [PC_W-1:0]   pc,
    output logic              zf,
    output logic              halted
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic                zf_q, zf_d;
    logic [15:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   regs_d [NREG];

    logic [3:0]          opc;
    logic [3:0]          wr_idx;
    logic                wr_en;
    logic [DATA_W-1:0]   wr_dat;
    logic [DATA_W-1:0]   src0_val, src1_val, alu_res, imm_dat;
    logic [PC_W-1:0]     pc_inc, imm_pc;

    assign opc     = ir_q[15:12];
    assign wr_idx  = ir_q[11:8];
    assign imm_dat = DATA_W'(ir_q[7:0]);
    assign imm_pc  = ir_q[PC_W-1:0];
    assign pc_inc  = pc_q + PC_W'(1);

    // Indices at or above NREG have no storage and read as zero.
    always_comb begin
        src0_val = '0;
        src1_val = '0;
        for (int i = 0; i < NREG; i++) begin
            if (ir_q[7:4] == 4'(i)) src0_val = regs_q[i];
            if (ir_q[3:0] == 4'(i)) src1_val = regs_q[i];
        end
    end

    always_comb begin
        alu_res = '0;
        case (opc)
            4'h2:    alu_res = src0_val + src1_val;
            4'h3:    alu_res = src0_val - src1_val;
            4'h4:    alu_res = src0_val & src1_val;
            4'h5:    alu_res = src0_val | src1_val;
            4'h6:    alu_res = src0_val ^ src1_val;
            4'h7:    alu_res = src0_val << 1;
            4'h8:    alu_res = src0_val >> 1;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        zf_d    = zf_q;
        ir_d    = ir_q;
        wr_en   = 1'b0;
        wr_dat  = '0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (opc)
                    4'h1: begin
                        wr_en  = 1'b1;
                        wr_dat = imm_dat;
                    end
                    4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                        wr_en  = 1'b1;
                        wr_dat = alu_res;
                        zf_d   = (alu_res == '0);
                    end
                    4'h9, 4'hA: begin
                        state_d = S_MEM;
                        pc_d    = pc_q;
                    end
                    4'hB: pc_d = imm_pc;
                    4'hC: pc_d = zf_q ? imm_pc : pc_inc;
                    4'hD: pc_d = zf_q ? pc_inc : imm_pc;
                    4'hF: begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (opc == 4'h9) begin
                        wr_en  = 1'b1;
                        wr_dat = dmem_rdata;
                    end
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = (wr_en && wr_idx == 4'(i)) ? wr_dat : regs_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            zf_q    <= 1'b0;
            ir_q    <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            zf_q    <= zf_d;
            ir_q    <= ir_d;
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
        end
    end

    // Requests come from the state register alone, so an async reset drops them at once.
    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = dmem_req && (opc == 4'hA);
    assign dmem_addr  = dmem_req ? src1_val : '0;
    assign dmem_wdata = dmem_req ? src0_val : '0;
    assign pc         = pc_q;
    assign zf         = zf_q;
    assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_core_param.sv
// Scoreboarded bench: default core with programmable wait-states, plus a DATA_W=16/NREG=4 core.
module tb_cpu_core_param;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } dacc_t;

    logic        clk;
    logic        rst, rst2;

    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, zf, halted;
    logic [5:0]  imem_addr, pc;
    logic [15:0] imem_data;
    logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;

    logic        imem_req2, imem_ack2, dmem_req2, dmem_we2, dmem_ack2, zf2, halted2;
    logic [5:0]  imem_addr2, pc2;
    logic [15:0] imem_data2;
    logic [15:0] dmem_addr2, dmem_wdata2, dmem_rdata2;

    logic [15:0] imem  [64];
    logic [15:0] prog2 [64];
    logic [7:0]  dmem  [256];

    int          imem_wait, dmem_wait;
    logic        stray_ack;
    int          n_chk, n_pass;

    logic [5:0]  fq [$];
    dacc_t       dq [$];
    dacc_t       dq2 [$];

    cpu_core_param dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .pc(pc), .zf(zf), .halted(halted)
    );

    cpu_core_param #(.DATA_W(16), .PC_W(6), .NREG(4)) dut2 (
        .clk(clk), .rst(rst2),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_data(imem_data2),
        .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_addr(dmem_addr2), .dmem_wdata(dmem_wdata2),
        .dmem_rdata(dmem_rdata2), .dmem_ack(dmem_ack2),
        .pc(pc2), .zf(zf2), .halted(halted2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic miss(input string name, input logic [63:0] act);
        n_chk++;
        $display("FAIL %s: got %0h with no expected entry", name, act);
    endtask

    task automatic push_f(input int a);
        fq.push_back(6'(a));
    endtask

    task automatic push_d(input logic we, input int a, input int d);
        dq.push_back(dacc_t'{we, 16'(a), 16'(d)});
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", {dmem_req, dmem_we}, 0);
        chk("rst_pc", pc, 0);
        chk("rst_zf_halted", {zf, halted}, 0);
        rst = 1'b1;
        #1;
        chk("idle_imem_req", imem_req, 0);
    endtask

    task automatic wait_halt(input int maxc);
        int k;
        k = 0;
        while (!halted && k < maxc) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("halt_reached", halted, 1);
    endtask

    task automatic chk_queues(input string name);
        chk({name, "_fetch_q_empty"}, fq.size(), 0);
        chk({name, "_data_q_empty"}, dq.size(), 0);
    endtask

    // Memory responders: acks are decided at the falling edge for the next rising edge.
    initial begin
        int icnt, dcnt;
        icnt = 0;
        dcnt = 0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (icnt >= imem_wait) begin
                    imem_ack  = 1'b1;
                    imem_data = imem[imem_addr];
                    icnt      = 0;
                end else begin
                    imem_ack = 1'b0;
                    icnt++;
                end
            end else begin
                imem_ack = 1'b0;
                icnt     = 0;
            end
            if (dmem_req) begin
                if (dcnt >= dmem_wait) begin
                    dmem_ack = 1'b1;
                    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                    else         dmem_rdata = dmem[dmem_addr];
                    dcnt = 0;
                end else begin
                    dmem_ack = 1'b0;
                    dcnt++;
                end
            end else begin
                dmem_ack = stray_ack;
                dcnt     = 0;
            end
            imem_ack2   = imem_req2;
            imem_data2  = prog2[imem_addr2];
            dmem_ack2   = dmem_req2;
            dmem_rdata2 = (dmem_addr2 == 16'h0040) ? 16'h8000 : 16'h0000;
        end
    end

    // Monitor: pops the scoreboard on every completed handshake and checks hold stability.
    initial begin
        logic  p_ireq, p_iack, p_dreq, p_dack;
        logic [5:0] p_iaddr;
        dacc_t p_d, cur;
        p_ireq = 1'b0; p_iack = 1'b0; p_dreq = 1'b0; p_dack = 1'b0;
        p_iaddr = '0; p_d = '0;
        forever begin
            @(negedge clk);
            #1;
            cur = dacc_t'{dmem_we, 16'(dmem_addr), 16'(dmem_wdata)};
            if (imem_req && imem_ack) begin
                if (fq.size() == 0) miss("fetch_extra", imem_addr);
                else chk("fetch_addr", imem_addr, fq.pop_front());
            end
            if (dmem_req && dmem_ack) begin
                if (dq.size() == 0) miss("dmem_extra", cur);
                else chk("dmem_access", cur, dq.pop_front());
            end
            if (p_ireq && !p_iack && imem_req) chk("imem_addr_stable", imem_addr, p_iaddr);
            if (p_dreq && !p_dack && dmem_req) chk("dmem_stable", cur, p_d);
            if (!dmem_req) chk("dmem_idle_zero", cur, 0);
            if (dmem_req2 && dmem_ack2) begin
                cur = dacc_t'{dmem_we2, dmem_addr2, dmem_wdata2};
                if (dq2.size() == 0) miss("dmem2_extra", cur);
                else chk("dmem2_access", cur, dq2.pop_front());
            end
            p_ireq = imem_req; p_iack = imem_ack; p_iaddr = imem_addr;
            p_dreq = dmem_req; p_dack = dmem_ack; p_d = dacc_t'{dmem_we, 16'(dmem_addr), 16'(dmem_wdata)};
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b0; rst2 = 1'b0;
        imem_ack = 1'b0; imem_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        imem_ack2 = 1'b0; imem_data2 = '0; dmem_ack2 = 1'b0; dmem_rdata2 = '0;
        imem_wait = 0; dmem_wait = 0; stray_ack = 1'b0;
        for (int i = 0; i < 256; i++) dmem[i] = 8'h00;

        // Wide core: r7 does not exist, LDI zero-extends, SHL of 0x8000 clears and sets zf.
        for (int i = 0; i < 64; i++) prog2[i] = 16'hF000;
        prog2[0] = 16'h1712; prog2[1] = 16'h11FF; prog2[2] = 16'hA071; prog2[3] = 16'hA011;
        prog2[4] = 16'h1340; prog2[5] = 16'h9203; prog2[6] = 16'h7220; prog2[7] = 16'hA023;
        prog2[8] = 16'hF000;
        dq2.push_back(dacc_t'{1'b1, 16'h00FF, 16'h0000});
        dq2.push_back(dacc_t'{1'b1, 16'h00FF, 16'h00FF});
        dq2.push_back(dacc_t'{1'b0, 16'h0040, 16'h0000});
        dq2.push_back(dacc_t'{1'b1, 16'h0040, 16'h0000});

        // ALU, flag, taken JZ, 8-bit wraparound ADD, untaken JNZ, HALT.
        clear_imem();
        imem[0] = 16'h1105; imem[1] = 16'h1205; imem[2] = 16'h3312; imem[3] = 16'hC010;
        imem[16] = 16'h14FF; imem[17] = 16'h5744; imem[18] = 16'h1501; imem[19] = 16'h2645;
        imem[20] = 16'hA067; imem[21] = 16'hA037; imem[22] = 16'hA017; imem[23] = 16'hD030;
        imem[24] = 16'hF000;
        for (int a = 0; a < 4; a++) push_f(a);
        for (int a = 16; a < 25; a++) push_f(a);
        push_d(1'b1, 8'hFF, 8'h00);
        push_d(1'b1, 8'hFF, 8'h00);
        push_d(1'b1, 8'hFF, 8'h05);
        @(negedge clk);
        rst2 = 1'b1;
        do_reset();
        repeat (9) @(posedge clk);
        #1;
        chk("jz_pc_after_8", pc, 6'h10);
        chk("sub_zf", zf, 1);
        wait_halt(200);
        chk("a_pc_final", pc, 6'h18);
        chk("a_zf_final", zf, 1);
        begin
            int reqs;
            reqs = 0;
            repeat (20) begin
                @(negedge clk);
                #1;
                if (imem_req || dmem_req) reqs++;
            end
            chk("halt_no_requests", reqs, 0);
            chk("halt_sticky", halted, 1);
        end
        chk_queues("a");
        chk("w16_halted", halted2, 1);
        chk("w16_zf", zf2, 1);
        chk("w16_pc", pc2, 6'h08);
        chk("w16_data_q_empty", dq2.size(), 0);

        // Wait-states on both memories; LD must return what ST wrote.
        imem_wait = 3; dmem_wait = 2;
        dmem[8'h20] = 8'h00;
        clear_imem();
        imem[0] = 16'h1477; imem[1] = 16'h1520; imem[2] = 16'hA045; imem[3] = 16'h9605;
        imem[4] = 16'hA065; imem[5] = 16'hF000;
        for (int a = 0; a < 6; a++) push_f(a);
        push_d(1'b1, 8'h20, 8'h77);
        push_d(1'b0, 8'h20, 8'h00);
        push_d(1'b1, 8'h20, 8'h77);
        do_reset();
        wait_halt(400);
        chk("b_pc_final", pc, 6'h05);
        chk_queues("b");

        // PC wrap from 0x3F, JMP immediate truncation, stray dmem acks.
        imem_wait = 0; dmem_wait = 0; stray_ack = 1'b1;
        clear_imem();
        imem[0] = 16'hD03F; imem[63] = 16'h3111; imem[1] = 16'hB0C5; imem[5] = 16'hF000;
        push_f(0); push_f(63); push_f(0); push_f(1); push_f(5);
        do_reset();
        wait_halt(100);
        chk("c_pc_final", pc, 6'h05);
        chk("c_zf_final", zf, 1);
        chk_queues("c");
        stray_ack = 1'b0;

        // Reset in the middle of a stalled load, then a clean rerun.
        dmem_wait = 1000;
        dmem[8'h30] = 8'h5A;
        clear_imem();
        imem[0] = 16'h1130; imem[1] = 16'h9201; imem[2] = 16'hF000;
        push_f(0); push_f(1);
        do_reset();
        begin
            int k;
            k = 0;
            while (!dmem_req && k < 50) begin
                @(negedge clk);
                #1;
                k++;
            end
            chk("d_mem_reached", dmem_req, 1);
            chk("d_mem_addr", dmem_addr, 8'h30);
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("d_async_dmem_req", dmem_req, 0);
        chk("d_async_dmem_addr", dmem_addr, 0);
        chk("d_async_pc", pc, 0);
        chk("d_fetch_q_mid", fq.size(), 0);
        dmem_wait = 0;
        push_f(0); push_f(1); push_f(2);
        push_d(1'b0, 8'h30, 8'h00);
        do_reset();
        wait_halt(100);
        chk("d_pc_final", pc, 6'h02);
        chk_queues("d");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
